// File: rtl/clb_config_loader_pkg.sv
// Shared constants for the CLB configuration loader: frame geometry, CLB field map,
// loader states and the power-on CLB configuration.
package clb_cfg_pkg;

    localparam int CFG_W   = 37;
    localparam int FRAME_W = CFG_W + 1;
    localparam int IDX_W   = 6;

    // CLB field map; bit 36 is the first data bit on the wire
    localparam int FLOPORLATCH_BIT = 36;
    localparam int DQMUX2_BIT      = 35;
    localparam int DQMUX1_BIT      = 34;
    localparam int O2M_LSB         = 28;
    localparam int O2M_W           = 6;
    localparam int COMBOPT_LSB     = 26;
    localparam int COMBOPT_W       = 2;
    localparam int MUX_LSB         = 16;
    localparam int MUX_W           = 10;
    localparam int MEM_LSB         = 0;
    localparam int MEM_W           = 16;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        SHIFT,
        DONE,
        ERROR
    } state_t;

    localparam logic [CFG_W-1:0] CLB_CFG_DEFAULT = 37'h3_802A_0116;

endpackage

// File: rtl/clb_config_loader_if.sv
// Serial bitstream port: one bit per din_valid & din_ready handshake, MSB first.
// The loader is the slave; the device config port is the master.
interface clb_config_loader_if;
    logic din;
    logic din_valid;
    logic din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/clb_config_loader_frame_shifter.sv
// Collects CFG_W data bits plus an odd-parity bit; frame_done/frame_ok are combinational
// on the accepted parity bit. Advances only on i_bit_vld, so upstream stalls are free.
module clb_frame_shifter
    import clb_cfg_pkg::*;
(
    input  logic             K,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_bit_vld,
    input  logic             i_bit,
    output logic             o_frame_done,
    output logic             o_frame_ok,
    output logic [CFG_W-1:0] o_frame_data
);

    logic [CFG_W-1:0] r_sr;
    logic [5:0]       r_cnt;
    logic             r_par;

    // The parity bit is never stored: data is complete once it arrives.
    assign o_frame_done = i_bit_vld && (r_cnt == 6'(FRAME_W - 1));
    assign o_frame_ok   = r_par ^ i_bit;
    assign o_frame_data = r_sr;

    always_ff @(posedge K or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_par <= 1'b0;
        end else if (i_clr || o_frame_done) begin
            r_cnt <= '0;
            r_par <= 1'b0;
        end else if (i_bit_vld) begin
            r_sr  <= {r_sr[CFG_W-2:0], i_bit};
            r_cnt <= r_cnt + 6'd1;
            r_par <= r_par ^ i_bit;
        end
    end

endmodule

// File: rtl/clb_config_loader.sv
// Hunts the bitstream for PREAMBLE, then commits one parity-checked frame per CLB slot;
// a slot is written one cycle after its parity bit. Stalls on din_valid gaps; ready only in HUNT/SHIFT.
module clb_config_loader
    import clb_cfg_pkg::*;
#(
    parameter int         NUM_CLB  = 4,
    parameter logic [7:0] PREAMBLE = 8'hB2
) (
    input  logic                     K,
    input  logic                     rst_n,
    input  logic                     start,
    clb_config_loader_if.slave       s_in,
    output logic [NUM_CLB*CFG_W-1:0] cfg_data,
    output logic                     cfg_update,
    output logic [IDX_W-1:0]         cfg_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t                   r_state, w_state_nxt;
    logic [7:0]               r_win;
    logic [7:0]               w_win_nxt;
    logic [NUM_CLB*CFG_W-1:0] r_cfg_data;
    logic                     r_cfg_update;
    logic [IDX_W-1:0]         r_cfg_idx;
    logic                     w_active, w_accept, w_hunt_hit, w_sh_bit, w_last, w_commit;
    logic                     w_frame_done, w_frame_ok;
    logic [CFG_W-1:0]         w_frame_data;

    assign w_active       = (r_state == HUNT) || (r_state == SHIFT);
    assign s_in.din_ready = w_active;
    // start takes priority: a bit handshaken in the same cycle is dropped
    assign w_accept       = s_in.din_valid && w_active && !start;
    assign w_win_nxt      = {r_win[6:0], s_in.din};
    assign w_hunt_hit     = (r_state == HUNT) && w_accept && (w_win_nxt == PREAMBLE);
    assign w_sh_bit       = (r_state == SHIFT) && w_accept;
    assign w_last         = (r_cfg_idx == IDX_W'(NUM_CLB - 1));
    assign w_commit       = w_frame_done && w_frame_ok;

    clb_frame_shifter u_shifter (
        .K            (K),
        .rst_n        (rst_n),
        .i_clr        (start),
        .i_bit_vld    (w_sh_bit),
        .i_bit        (s_in.din),
        .o_frame_done (w_frame_done),
        .o_frame_ok   (w_frame_ok),
        .o_frame_data (w_frame_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = HUNT;
        end else begin
            case (r_state)
                HUNT:    if (w_hunt_hit) w_state_nxt = SHIFT;
                SHIFT: begin
                    if (w_frame_done) begin
                        if (!w_frame_ok)  w_state_nxt = ERROR;
                        else if (w_last)  w_state_nxt = DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge K or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge K or negedge rst_n) begin
        if (!rst_n) begin
            r_win        <= '0;
            r_cfg_idx    <= '0;
            r_cfg_update <= 1'b0;
            r_cfg_data   <= {NUM_CLB{CLB_CFG_DEFAULT}};
        end else begin
            r_cfg_update <= w_commit;
            if (start) begin
                r_win     <= '0;
                r_cfg_idx <= '0;
            end else begin
                if ((r_state == HUNT) && w_accept) r_win <= w_win_nxt;
                // idx moves on the cycle after the pulse; it stays on the last slot in DONE
                if (r_cfg_update && (r_state == SHIFT)) r_cfg_idx <= r_cfg_idx + 1'b1;
            end
            if (w_commit) r_cfg_data[r_cfg_idx*CFG_W +: CFG_W] <= w_frame_data;
        end
    end

    assign cfg_data   = r_cfg_data;
    assign cfg_update = r_cfg_update;
    assign cfg_idx    = r_cfg_idx;
    assign busy       = w_active;
    assign done       = (r_state == DONE);
    assign err        = (r_state == ERROR);

endmodule
